// File: rtl/alu_pkg.sv
// Shared ALU definitions: widths, opcode encodings, arbiter FSM states and
// the legality check used to flag unsupported opcodes.
package alu_pkg;

   localparam int OPC_W  = 4;
   localparam int IMM_W  = 21;
   localparam int DATA_W = 32;
   localparam int CMP_W  = 4;

   localparam logic [OPC_W-1:0] OPC_MOV = 4'd0;
   localparam logic [OPC_W-1:0] OPC_MVN = 4'd1;
   localparam logic [OPC_W-1:0] OPC_AND = 4'd2;
   localparam logic [OPC_W-1:0] OPC_ORR = 4'd3;
   localparam logic [OPC_W-1:0] OPC_EOR = 4'd4;
   localparam logic [OPC_W-1:0] OPC_LSL = 4'd5;
   localparam logic [OPC_W-1:0] OPC_LSR = 4'd6;
   localparam logic [OPC_W-1:0] OPC_ADD = 4'd7;
   localparam logic [OPC_W-1:0] OPC_SUB = 4'd8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   function automatic logic is_legal_opcode(input logic [OPC_W-1:0] opc);
      logic legal;
      case (opc)
         OPC_MOV, OPC_MVN, OPC_AND, OPC_ORR, OPC_EOR,
         OPC_LSL, OPC_LSR, OPC_ADD, OPC_SUB: legal = 1'b1;
         default:                            legal = 1'b0;
      endcase
      return legal;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first valid requester at or after ptr,
// wrapping at NUM_REQ. The pointer register lives in the caller.
module rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int ID_W    = 3
) (
   input  logic [NUM_REQ-1:0] valid,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    grant_idx,
   output logic               any_valid
);

   logic found;

   // Outer loop walks priority order starting at ptr; constant indices only.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && valid[i] && (((int'(ptr) + k) % NUM_REQ) == i)) begin
               grant[i]  = 1'b1;
               grant_idx = ID_W'(i);
               found     = 1'b1;
            end
         end
      end
   end

   assign any_valid = |valid;

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU among NUM_REQ requesters: round-robin grant,
// registered ALU operands and a single registered response slot.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int ID_W    = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_REQ-1:0]      req_valid,
   output logic [NUM_REQ-1:0]      req_ready,
   input  logic [4*NUM_REQ-1:0]    req_opcode,
   input  logic [NUM_REQ-1:0]      req_mode,
   input  logic [32*NUM_REQ-1:0]   req_a,
   input  logic [32*NUM_REQ-1:0]   req_b,
   input  logic [21*NUM_REQ-1:0]   req_imm,
   output logic [31:0]             alu_a,
   output logic [31:0]             alu_b,
   output logic [20:0]             alu_imm,
   output logic [3:0]              alu_opcode,
   output logic                    alu_mode,
   input  logic [31:0]             alu_result,
   input  logic [3:0]              alu_cmp,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [ID_W-1:0]         rsp_id,
   output logic [31:0]             rsp_result,
   output logic [3:0]              rsp_cmp,
   output logic                    rsp_err
);

   logic [OPC_W-1:0]  opc_arr [NUM_REQ];
   logic [DATA_W-1:0] a_arr   [NUM_REQ];
   logic [DATA_W-1:0] b_arr   [NUM_REQ];
   logic [IMM_W-1:0]  imm_arr [NUM_REQ];

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign opc_arr[gi] = req_opcode[gi*OPC_W +: OPC_W];
      assign a_arr[gi]   = req_a[gi*DATA_W +: DATA_W];
      assign b_arr[gi]   = req_b[gi*DATA_W +: DATA_W];
      assign imm_arr[gi] = req_imm[gi*IMM_W +: IMM_W];
   end

   state_e            state_q, state_d;
   logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]   id_q, id_d;
   logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
   logic [IMM_W-1:0]  alu_imm_q, alu_imm_d;
   logic [OPC_W-1:0]  alu_opcode_q, alu_opcode_d;
   logic              alu_mode_q, alu_mode_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
   logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
   logic [CMP_W-1:0]  rsp_cmp_q, rsp_cmp_d;
   logic              rsp_err_q, rsp_err_d;

   logic [NUM_REQ-1:0] grant;
   logic [ID_W-1:0]    grant_idx;
   logic               any_valid;
   logic               grant_en;
   logic [OPC_W-1:0]   sel_opc;
   logic [DATA_W-1:0]  sel_a, sel_b;
   logic [IMM_W-1:0]   sel_imm;
   logic               sel_mode;
   logic               op_legal;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_rr (
      .valid     (req_valid),
      .ptr       (rr_ptr_q),
      .grant     (grant),
      .grant_idx (grant_idx),
      .any_valid (any_valid)
   );

   // One-hot mux keyed on the grant vector.
   always_comb begin
      sel_opc  = '0;
      sel_a    = '0;
      sel_b    = '0;
      sel_imm  = '0;
      sel_mode = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            sel_opc  = opc_arr[i];
            sel_a    = a_arr[i];
            sel_b    = b_arr[i];
            sel_imm  = imm_arr[i];
            sel_mode = req_mode[i];
         end
      end
   end

   assign op_legal = is_legal_opcode(alu_opcode_q);

   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      id_d         = id_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      alu_imm_d    = alu_imm_q;
      alu_opcode_d = alu_opcode_q;
      alu_mode_d   = alu_mode_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_id_d     = rsp_id_q;
      rsp_result_d = rsp_result_q;
      rsp_cmp_d    = rsp_cmp_q;
      rsp_err_d    = rsp_err_q;
      grant_en     = 1'b0;

      case (state_q)
         ST_IDLE: grant_en = any_valid;
         ST_EXEC: begin
            rsp_valid_d  = 1'b1;
            rsp_id_d     = id_q;
            rsp_result_d = op_legal ? alu_result : '0;
            rsp_cmp_d    = alu_cmp;
            rsp_err_d    = !op_legal;
            rr_ptr_d     = (id_q == ID_W'(NUM_REQ-1)) ? '0 : id_q + ID_W'(1);
            state_d      = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               grant_en    = any_valid;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // A grant from IDLE or a drained RESP slot loads the operand registers.
      if (grant_en) begin
         alu_a_d      = sel_a;
         alu_b_d      = sel_b;
         alu_imm_d    = sel_imm;
         alu_opcode_d = sel_opc;
         alu_mode_d   = sel_mode;
         id_d         = grant_idx;
         state_d      = ST_EXEC;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         rr_ptr_q     <= '0;
         id_q         <= '0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_imm_q    <= '0;
         alu_opcode_q <= '0;
         alu_mode_q   <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= '0;
         rsp_result_q <= '0;
         rsp_cmp_q    <= '0;
         rsp_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         id_q         <= id_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         alu_imm_q    <= alu_imm_d;
         alu_opcode_q <= alu_opcode_d;
         alu_mode_q   <= alu_mode_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_result_q <= rsp_result_d;
         rsp_cmp_q    <= rsp_cmp_d;
         rsp_err_q    <= rsp_err_d;
      end
   end

   // Gated by rst so no accept is signalled while reset is held.
   assign req_ready  = (grant_en && !rst) ? grant : '0;
   assign alu_a      = alu_a_q;
   assign alu_b      = alu_b_q;
   assign alu_imm    = alu_imm_q;
   assign alu_opcode = alu_opcode_q;
   assign alu_mode   = alu_mode_q;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_id     = rsp_id_q;
   assign rsp_result = rsp_result_q;
   assign rsp_cmp    = rsp_cmp_q;
   assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU attached to the
// alu_* operand outputs; expected values are hand-computed in the table.
module tb_alu_arbiter;

   localparam int NR   = 2;
   localparam int ID_W = 3;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NR-1:0]     req_valid = '0;
   logic [NR-1:0]     req_ready;
   logic [4*NR-1:0]   req_opcode = '0;
   logic [NR-1:0]     req_mode = '0;
   logic [32*NR-1:0]  req_a = '0;
   logic [32*NR-1:0]  req_b = '0;
   logic [21*NR-1:0]  req_imm = '0;
   logic [31:0]       alu_a, alu_b;
   logic [20:0]       alu_imm;
   logic [3:0]        alu_opcode;
   logic              alu_mode;
   logic [31:0]       alu_result;
   logic [3:0]        alu_cmp;
   logic              rsp_valid;
   logic              rsp_ready = 1'b1;
   logic [ID_W-1:0]   rsp_id;
   logic [31:0]       rsp_result;
   logic [3:0]        rsp_cmp;
   logic              rsp_err;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   alu_arbiter #(.NUM_REQ(NR), .ID_W(ID_W)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
      .req_mode(req_mode), .req_a(req_a), .req_b(req_b), .req_imm(req_imm),
      .alu_a(alu_a), .alu_b(alu_b), .alu_imm(alu_imm), .alu_opcode(alu_opcode),
      .alu_mode(alu_mode), .alu_result(alu_result), .alu_cmp(alu_cmp),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_result(rsp_result), .rsp_cmp(rsp_cmp), .rsp_err(rsp_err)
   );

   // Behavioural ALU: operand 2 is b or zero-extended imm; flags {gt,lt,ne,eq}.
   logic [31:0] op2;
   always_comb begin
      op2 = alu_mode ? alu_b : {11'd0, alu_imm};
      case (alu_opcode)
         4'd0:    alu_result = op2;
         4'd1:    alu_result = ~op2;
         4'd2:    alu_result = alu_a & op2;
         4'd3:    alu_result = alu_a | op2;
         4'd4:    alu_result = alu_a ^ op2;
         4'd5:    alu_result = alu_a << op2[4:0];
         4'd6:    alu_result = alu_a >> op2[4:0];
         4'd7:    alu_result = alu_a + op2;
         4'd8:    alu_result = alu_a - op2;
         default: alu_result = 32'hDEAD_BEEF;
      endcase
      alu_cmp = {alu_a > op2, alu_a < op2, alu_a != op2, alu_a == op2};
   end

   typedef struct {
      int          req;
      logic [3:0]  opc;
      logic        mode;
      logic [31:0] a;
      logic [31:0] b;
      logic [20:0] imm;
      logic [31:0] exp_res;
      logic [3:0]  exp_cmp;
      logic        exp_err;
   } vec_t;

   vec_t vecs [12];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
      end
   endtask

   task automatic set_req(input int r, input logic [3:0] opc, input logic mode,
                          input logic [31:0] a, input logic [31:0] b, input logic [20:0] imm);
      req_opcode[r*4 +: 4]  = opc;
      req_mode[r]           = mode;
      req_a[r*32 +: 32]     = a;
      req_b[r*32 +: 32]     = b;
      req_imm[r*21 +: 21]   = imm;
   endtask

   // Waits (at negedges) up to 20 cycles for any req_ready bit.
   task automatic wait_ready(input string nm);
      int cnt = 0;
      while (req_ready == '0 && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      if (req_ready == '0) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: req_ready timeout after %0d cycles", nm, cnt);
      end
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, "_rsp_valid"},  {31'd0, rsp_valid}, 32'd0);
      chk({nm, "_rsp_id"},     {29'd0, rsp_id}, 32'd0);
      chk({nm, "_rsp_result"}, rsp_result, 32'd0);
      chk({nm, "_rsp_cmp"},    {28'd0, rsp_cmp}, 32'd0);
      chk({nm, "_rsp_err"},    {31'd0, rsp_err}, 32'd0);
      chk({nm, "_alu_a"},      alu_a, 32'd0);
      chk({nm, "_alu_b"},      alu_b, 32'd0);
      chk({nm, "_alu_imm"},    {11'd0, alu_imm}, 32'd0);
      chk({nm, "_alu_opc"},    {27'd0, alu_mode, alu_opcode}, 32'd0);
      chk({nm, "_req_ready"},  {30'd0, req_ready}, 32'd0);
   endtask

   logic [NR-1:0] exp_grant;
   int            exp_id;

   initial begin
      vecs[0]  = '{0, 4'd7, 1'b1, 32'd5,          32'd7,          21'd0,       32'd12,         4'b0110, 1'b0};
      vecs[1]  = '{1, 4'd8, 1'b0, 32'd100,        32'd0,          21'd1,       32'd99,         4'b1010, 1'b0};
      vecs[2]  = '{0, 4'd2, 1'b1, 32'hF0F0_00FF,  32'h0FF0_0F0F,  21'd0,       32'h00F0_000F,  4'b1010, 1'b0};
      vecs[3]  = '{1, 4'd3, 1'b0, 32'h0000_1000,  32'd0,          21'h00ABC,   32'h0000_1ABC,  4'b1010, 1'b0};
      vecs[4]  = '{0, 4'd4, 1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  21'd0,       32'd0,          4'b0001, 1'b0};
      vecs[5]  = '{1, 4'd5, 1'b0, 32'd1,          32'd0,          21'd4,       32'd16,         4'b0110, 1'b0};
      vecs[6]  = '{0, 4'd6, 1'b1, 32'h8000_0000,  32'd31,         21'd0,       32'd1,          4'b1010, 1'b0};
      vecs[7]  = '{1, 4'd0, 1'b0, 32'd0,          32'd0,          21'h1F_FFFF, 32'h001F_FFFF,  4'b0110, 1'b0};
      vecs[8]  = '{0, 4'd1, 1'b1, 32'd3,          32'd0,          21'd0,       32'hFFFF_FFFF,  4'b1010, 1'b0};
      vecs[9]  = '{1, 4'hF, 1'b1, 32'd2,          32'd2,          21'd0,       32'd0,          4'b0001, 1'b1};
      vecs[10] = '{0, 4'd7, 1'b1, 32'hFFFF_FFFF,  32'd1,          21'd0,       32'd0,          4'b1010, 1'b0};
      vecs[11] = '{0, 4'd9, 1'b1, 32'd1,          32'd2,          21'd0,       32'd0,          4'b0110, 1'b1};

      // Reset state, with a request already pending.
      set_req(0, 4'd7, 1'b1, 32'd5, 32'd7, 21'd0);
      req_valid = 2'b01;
      @(negedge clk);
      @(negedge clk);
      chk_all_zero("reset");
      req_valid = '0;
      rst = 1'b0;
      @(negedge clk);

      // Table-driven single operations, one requester at a time.
      for (int v = 0; v < 12; v++) begin
         set_req(vecs[v].req, vecs[v].opc, vecs[v].mode, vecs[v].a, vecs[v].b, vecs[v].imm);
         req_valid = '0;
         req_valid[vecs[v].req] = 1'b1;
         #1;
         wait_ready($sformatf("v%0d_wait", v));
         exp_grant = '0;
         exp_grant[vecs[v].req] = 1'b1;
         chk($sformatf("v%0d_req_ready", v), {30'd0, req_ready}, {30'd0, exp_grant});
         @(posedge clk);
         #1 req_valid = '0;
         @(negedge clk);
         chk($sformatf("v%0d_alu_opcode", v), {28'd0, alu_opcode}, {28'd0, vecs[v].opc});
         chk($sformatf("v%0d_rsp_valid_exec", v), {31'd0, rsp_valid}, 32'd0);
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("v%0d_rsp_valid", v), {31'd0, rsp_valid}, 32'd1);
         chk($sformatf("v%0d_rsp_id", v), {29'd0, rsp_id}, vecs[v].req);
         chk($sformatf("v%0d_rsp_result", v), rsp_result, vecs[v].exp_res);
         chk($sformatf("v%0d_rsp_cmp", v), {28'd0, rsp_cmp}, {28'd0, vecs[v].exp_cmp});
         chk($sformatf("v%0d_rsp_err", v), {31'd0, rsp_err}, {31'd0, vecs[v].exp_err});
         $display("vec %0d: req=%0d opc=%0h -> id=%0d result=0x%0h cmp=%b err=%b",
                  v, vecs[v].req, vecs[v].opc, rsp_id, rsp_result, rsp_cmp, rsp_err);
         @(negedge clk);
      end

      // Fairness: both valid continuously. Last table op came from req0, so req1 goes first.
      set_req(0, 4'd7, 1'b1, 32'd10, 32'd1, 21'd0);
      set_req(1, 4'd8, 1'b1, 32'd10, 32'd1, 21'd0);
      req_valid = 2'b11;
      #1;
      exp_id = 1;
      for (int n = 0; n < 16; n++) begin
         wait_ready($sformatf("fair%0d_wait", n));
         exp_grant = '0;
         exp_grant[exp_id] = 1'b1;
         chk($sformatf("fair%0d_grant", n), {30'd0, req_ready}, {30'd0, exp_grant});
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("fair%0d_ready_exec", n), {30'd0, req_ready}, 32'd0);
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("fair%0d_rsp_valid", n), {31'd0, rsp_valid}, 32'd1);
         chk($sformatf("fair%0d_rsp_id", n), {29'd0, rsp_id}, exp_id);
         chk($sformatf("fair%0d_result", n), rsp_result, (exp_id == 0) ? 32'd11 : 32'd9);
         $display("fair %0d: id=%0d result=%0d", n, rsp_id, rsp_result);
         exp_id = 1 - exp_id;
      end
      req_valid = '0;
      @(negedge clk);
      @(negedge clk);

      // Backpressure: ptr now points at req1. Response held for 5 cycles.
      set_req(0, 4'd7, 1'b1, 32'd5, 32'd7, 21'd0);
      set_req(1, 4'd8, 1'b0, 32'd100, 32'd0, 21'd1);
      rsp_ready = 1'b0;
      req_valid = 2'b11;
      #1;
      wait_ready("bp_wait");
      chk("bp_first_grant", {30'd0, req_ready}, 32'd2);
      @(posedge clk);
      @(negedge clk);
      @(posedge clk);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk($sformatf("bp%0d_rsp_valid", c), {31'd0, rsp_valid}, 32'd1);
         chk($sformatf("bp%0d_rsp_result", c), rsp_result, 32'd99);
         chk($sformatf("bp%0d_rsp_id", c), {29'd0, rsp_id}, 32'd1);
         chk($sformatf("bp%0d_rsp_cmp", c), {28'd0, rsp_cmp}, 32'b1010);
         chk($sformatf("bp%0d_req_ready", c), {30'd0, req_ready}, 32'd0);
         $display("bp cycle %0d: rsp_valid=%b result=%0d req_ready=%b", c, rsp_valid, rsp_result, req_ready);
      end
      rsp_ready = 1'b1;
      #1;
      chk("bp_release_grant", {30'd0, req_ready}, 32'd1);
      @(posedge clk);
      #1 req_valid = '0;
      @(negedge clk);
      chk("bp_rsp_valid_drop", {31'd0, rsp_valid}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk("bp_next_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_next_id", {29'd0, rsp_id}, 32'd0);
      chk("bp_next_result", rsp_result, 32'd12);
      chk("bp_next_cmp", {28'd0, rsp_cmp}, 32'b0110);
      $display("bp release: id=%0d result=%0d", rsp_id, rsp_result);
      @(negedge clk);

      // Reset during EXEC: ptr is at req1 now, so req1 is granted first.
      req_valid = 2'b11;
      #1;
      wait_ready("rst_wait");
      chk("rst_pre_grant", {30'd0, req_ready}, 32'd2);
      @(posedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
      chk_all_zero("rst_exec");
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      req_valid = '0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk($sformatf("rst_post%0d_rsp_valid", c), {31'd0, rsp_valid}, 32'd0);
      end
      req_valid = 2'b11;
      #1;
      chk("rst_ptr_grant", {30'd0, req_ready}, 32'd1);
      @(posedge clk);
      #1 req_valid = '0;
      @(posedge clk);
      @(negedge clk);
      chk("rst_post_result", rsp_result, 32'd12);
      chk("rst_post_id", {29'd0, rsp_id}, 32'd0);
      $display("after reset: id=%0d result=%0d", rsp_id, rsp_result);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
